// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl
//
// Captures one 256-sample window of the 16-bit audio stream into a
// double-buffered 512 x 8 waveform RAM. Capture begins at each positive-going
// zero crossing. Samples go into the half the display is not reading. The
// halves are swapped once the display reports idle.
//
// Ports:
//   clk                in   system clock, rising edge
//   reset              in   asynchronous reset, active low
//   new_sample_ready   in   one-cycle strobe, new_sample_in valid
//   new_sample_in      in   [15:0] signed audio sample
//   wave_display_idle  in   display not reading RAM, swap permitted
//   write_address      out  [8:0] {~read_index, count}
//   write_enable       out  RAM write strobe
//   write_sample       out  [7:0] offset-binary upper byte of sample
//   read_index         out  RAM half the display reads
//
// Build option:
//   WAVE_CAPTURE_TRIG_HYST_EN - when defined, the trigger also requires the
//   previous sample to be <= -256. Small negative noise then cannot arm a
//   capture.

module wave_capture_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        read_index_q, read_index_d;
    logic [15:0] prev_sample_q, prev_sample_d;
    logic        crossing;

    // Positive-going crossing: previous sample negative, current one
    // non-negative (zero counts as non-negative).
`ifdef WAVE_CAPTURE_TRIG_HYST_EN
    assign crossing = new_sample_ready
                    && ($signed(prev_sample_q) <= -16'sd256)
                    && !new_sample_in[15];
`else
    assign crossing = new_sample_ready
                    && ($signed(prev_sample_q) < 16'sd0)
                    && !new_sample_in[15];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ARMED;
            count_q       <= '0;
            read_index_q  <= 1'b0;
            prev_sample_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            read_index_q  <= read_index_d;
            prev_sample_q <= prev_sample_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        read_index_d  = read_index_q;
        prev_sample_d = new_sample_ready ? new_sample_in : prev_sample_q;

        case (state_q)
            ARMED: begin
                // The crossing sample itself is not written.
                if (crossing) begin
                    state_d = ACTIVE;
                    count_d = '0;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    // Increment wraps 255 -> 0 as the window completes.
                    count_d = count_q + 8'd1;
                    if (count_q == 8'hFF) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
                count_d = '0;
            end
        endcase
    end

    assign write_enable  = (state_q == ACTIVE) && new_sample_ready;
    assign write_address = {~read_index_q, count_q};
    assign write_sample  = {~new_sample_in[15], new_sample_in[14:8]};
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
module tb_wave_capture_ctrl;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks;
    int errors;

    wave_capture_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        new_sample_ready  = 1'b0;
        new_sample_in     = 16'h0000;
        wave_display_idle = 1'b0;
        repeat (3) tick();
        checks++;
        if (write_address !== 9'h100) begin
            errors++;
            $display("FAIL reset_addr: got %h expected %h", write_address, 9'h100);
        end
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %b expected 0", write_enable);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (read_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_ri: got %b expected 0", read_index);
        end
        checks++;
        if (write_sample !== 8'h80) begin
            errors++;
            $display("FAIL reset_ws: got %h expected 80", write_sample);
        end
        checks++;
        if (write_address !== 9'h100) begin
            errors++;
            $display("FAIL post_reset_addr: got %h expected 100", write_address);
        end
    endtask

    // Negative samples only, then the crossing strobe itself.
    task automatic test_no_trigger();
        new_sample_in    = 16'hF23C;
        new_sample_ready = 1'b0;
        #1;
        checks++;
        if (write_address !== 9'h100 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_neg: got addr %h we %b expected 100/0", write_address, write_enable);
        end
        checks++;
        if (write_sample !== 8'h72) begin
            errors++;
            $display("FAIL ws_neg: got %h expected 72", write_sample);
        end
        tick();
        new_sample_ready = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL neg_strobe_we: got %b expected 0", write_enable);
        end
        tick();
        // Negative after negative must not trigger
        new_sample_in = 16'hF23C;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL neg_neg_we: got %b expected 0", write_enable);
        end
        tick();
        new_sample_in = 16'h0245;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL crossing_sample_we: got %b expected 0", write_enable);
        end
        tick();
    endtask

    // Now ACTIVE with count=0. Write 64 samples, then reset mid-capture.
    task automatic test_reset_mid();
        new_sample_ready = 1'b1;
        new_sample_in    = 16'h1000;
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++;
            if (write_enable !== 1'b1 || write_address !== (9'h100 + 9'(i))) begin
                errors++;
                $display("FAIL mid_write[%0d]: got we %b addr %h expected 1/%h",
                         i, write_enable, write_address, 9'h100 + 9'(i));
            end
            tick();
        end
        #1;
        checks++;
        if (write_address !== 9'h140) begin
            errors++;
            $display("FAIL mid_count40: got %h expected 140", write_address);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (write_address !== 9'h100 || write_enable !== 1'b0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got addr %h we %b ri %b expected 100/0/0",
                     write_address, write_enable, read_index);
        end
        new_sample_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (write_address !== 9'h100 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL after_mid_reset: got addr %h ri %b expected 100/0", write_address, read_index);
        end
    endtask

    // Full 256-sample capture with a one-cycle gap and a spurious idle.
    task automatic test_capture();
        new_sample_ready = 1'b1;
        new_sample_in    = 16'hF23C;
        tick();
        new_sample_in = 16'h0245;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL cap_trigger_we: got %b expected 0", write_enable);
        end
        tick();
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                new_sample_ready = 1'b0;
                #1;
                checks++;
                if (write_enable !== 1'b0 || write_address !== 9'h180) begin
                    errors++;
                    $display("FAIL cap_gap: got we %b addr %h expected 0/180", write_enable, write_address);
                end
                tick();
                new_sample_ready = 1'b1;
            end
            wave_display_idle = (i >= 10 && i < 20);
            #1;
            checks++;
            if (write_enable !== 1'b1 || write_sample !== 8'h82
                || write_address !== (9'h100 + 9'(i))) begin
                errors++;
                $display("FAIL cap_write[%0d]: got we %b ws %h addr %h expected 1/82/%h",
                         i, write_enable, write_sample, write_address, 9'h100 + 9'(i));
            end
            tick();
        end
        wave_display_idle = 1'b0;
        // WAIT: strobes produce no writes, count wrapped to 0
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (write_enable !== 1'b0 || write_address !== 9'h100 || read_index !== 1'b0) begin
                errors++;
                $display("FAIL wait_nowrite[%0d]: got we %b addr %h ri %b expected 0/100/0",
                         i, write_enable, write_address, read_index);
            end
            tick();
        end
    endtask

    task automatic test_wait_swap();
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b1;
        #1;
        checks++;
        if (read_index !== 1'b0) begin
            errors++;
            $display("FAIL swap_before: got ri %b expected 0", read_index);
        end
        tick();
        wave_display_idle = 1'b0;
        checks++;
        if (read_index !== 1'b1 || write_address !== 9'h000) begin
            errors++;
            $display("FAIL swap_after: got ri %b addr %h expected 1/000", read_index, write_address);
        end
        tick();
        checks++;
        if (read_index !== 1'b1) begin
            errors++;
            $display("FAIL swap_hold: got ri %b expected 1", read_index);
        end
    endtask

    // Small negative noise followed by a positive sample.
    task automatic test_hyst();
        new_sample_ready = 1'b1;
        new_sample_in    = 16'hFFF0;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL hyst_neg_we: got %b expected 0", write_enable);
        end
        tick();
        new_sample_in = 16'h0001;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL hyst_cross_we: got %b expected 0", write_enable);
        end
        tick();
        new_sample_in = 16'h7F00;
        #1;
`ifdef WAVE_CAPTURE_TRIG_HYST_EN
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL hyst_no_trigger: got we %b expected 0", write_enable);
        end
        tick();
        // Exactly -256 is deep enough to trigger
        new_sample_in = 16'hFF00;
        tick();
        new_sample_in = 16'h0001;
        tick();
        new_sample_in = 16'h7F00;
        #1;
`endif
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h000 || write_sample !== 8'hFF) begin
            errors++;
            $display("FAIL hyst_trigger: got we %b addr %h ws %h expected 1/000/ff",
                     write_enable, write_address, write_sample);
        end
        tick();
        #1;
        checks++;
        if (write_address !== 9'h001) begin
            errors++;
            $display("FAIL hyst_next_addr: got %h expected 001", write_address);
        end
        new_sample_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_no_trigger();
        test_reset_mid();
        test_capture();
        test_wait_swap();
        test_hyst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
